// File: rtl/inst_rom_pkg.sv
// Shared widths and loader state encoding for the instruction ROM and its byte loader.
package inst_rom_pkg;

  localparam int unsigned REG_BUS_W       = 32;
  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned DEFAULT_ADDR_W  = 10;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_rom_ld_fsm.sv
// Byte-stream loader: handshake, byte assembly, word pointer and counters.
// Optional running checksum of written words when INST_ROM_CHECKSUM_EN is defined.
module inst_rom_ld_fsm
  import inst_rom_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_start,
  input  logic [ADDR_W:0]      ld_len,
  input  logic [BYTE_W-1:0]    ld_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  output logic                 ld_busy,
  output logic                 ld_done,
  output logic [ADDR_W:0]      ld_words,
`ifdef INST_ROM_CHECKSUM_EN
  output logic [REG_BUS_W-1:0] ld_checksum,
`endif
  output logic                 wr_en_c,
  output logic [ADDR_W-1:0]    wr_addr_c,
  output logic [REG_BUS_W-1:0] wr_data_c
);

  localparam int unsigned     ASM_W    = REG_BUS_W - BYTE_W;
  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   len_eff;
  logic              done_q, done_d;
  logic              ready_q, busy_q;
  logic              accept;
`ifdef INST_ROM_CHECKSUM_EN
  logic [REG_BUS_W-1:0] csum_q, csum_d;
`endif

  // Requests longer than the array are clamped to its depth.
  assign len_eff = (ld_len > DEPTH) ? DEPTH : ld_len;
  assign accept  = ready_q & ld_valid;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    words_d    = words_q;
    len_d      = len_q;
    done_d     = done_q;
`ifdef INST_ROM_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    wr_en_c    = 1'b0;
    wr_addr_c  = ptr_q;
    wr_data_c  = BIG_ENDIAN ? {asm_q, ld_data} : {ld_data, asm_q};

    unique case (state_q)
      LD_IDLE, LD_DONE: begin
        if (ld_start) begin
          ptr_d      = '0;
          byte_cnt_d = '0;
          words_d    = '0;
          len_d      = len_eff;
`ifdef INST_ROM_CHECKSUM_EN
          csum_d     = '0;
`endif
          if (len_eff == '0) begin
            state_d = LD_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LD_LOAD;
            done_d  = 1'b0;
          end
        end
      end
      LD_LOAD: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d = BIG_ENDIAN ? {asm_q[ASM_W-BYTE_W-1:0], ld_data}
                             : {ld_data, asm_q[ASM_W-1:BYTE_W]};
          // Fourth byte completes the word; it is written on this same edge.
          if (byte_cnt_q == 2'd3) begin
            wr_en_c = 1'b1;
            ptr_d   = ptr_q + PTR_ONE;
            words_d = words_q + WORD_ONE;
`ifdef INST_ROM_CHECKSUM_EN
            csum_d  = csum_q + wr_data_c;
`endif
            if (words_d == len_q) begin
              state_d = LD_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LD_IDLE;
      ptr_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      words_q    <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      words_q    <= words_d;
      len_q      <= len_d;
      done_q     <= done_d;
      ready_q    <= (state_d == LD_LOAD);
      busy_q     <= (state_d == LD_LOAD);
`ifdef INST_ROM_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign ld_ready = ready_q;
  assign ld_busy  = busy_q;
  assign ld_done  = done_q;
  assign ld_words = words_q;
`ifdef INST_ROM_CHECKSUM_EN
  assign ld_checksum = csum_q;
`endif

endmodule

// File: rtl/inst_rom.sv
// Instruction memory with same-cycle fetch port and a byte-stream loader that holds the CPU in reset.
// Define INST_ROM_CHECKSUM_EN to add the ld_checksum output.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rom_ce_in,
  input  logic [INST_ADDR_BUS_W-1:0] rom_addr_in,
  output logic [REG_BUS_W-1:0]       rom_data_out,
  input  logic                       ld_start,
  input  logic [ADDR_W:0]            ld_len,
  input  logic [BYTE_W-1:0]          ld_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  output logic                       ld_busy,
  output logic                       ld_done,
  output logic [ADDR_W:0]            ld_words,
`ifdef INST_ROM_CHECKSUM_EN
  output logic [REG_BUS_W-1:0]       ld_checksum,
`endif
  output logic                       cpu_hold
);

  logic [REG_BUS_W-1:0] mem [2**ADDR_W];
  logic                 wr_en_c;
  logic [ADDR_W-1:0]    wr_addr_c;
  logic [REG_BUS_W-1:0] wr_data_c;
  logic                 unused_addr;

  inst_rom_ld_fsm #(
    .ADDR_W     (ADDR_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_ld_fsm (
    .clk         (clk),
    .rst_n       (rst),
    .ld_start    (ld_start),
    .ld_len      (ld_len),
    .ld_data     (ld_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_busy     (ld_busy),
    .ld_done     (ld_done),
    .ld_words    (ld_words),
`ifdef INST_ROM_CHECKSUM_EN
    .ld_checksum (ld_checksum),
`endif
    .wr_en_c     (wr_en_c),
    .wr_addr_c   (wr_addr_c),
    .wr_data_c   (wr_data_c)
  );

  // Contents survive reset; only the loader control state is cleared.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= wr_data_c;
    end
  end

  // Byte offset and high address bits are don't-care: fetches alias modulo depth.
  assign rom_data_out = rom_ce_in ? mem[rom_addr_in[ADDR_W+1:2]] : '0;
  assign unused_addr  = ^{rom_addr_in[INST_ADDR_BUS_W-1:ADDR_W+2], rom_addr_in[1:0]};

  assign cpu_hold = ld_busy;

endmodule

// File: tb/tb_inst_rom.sv
// Bench for inst_rom: fetch vector table, hand-written loader corner cases, randomized loads vs a word-array model.
module tb_inst_rom;

  localparam int unsigned AW    = 10;
  localparam bit          BE    = 1'b1;
  localparam int          DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce_in;
  logic [31:0]   rom_addr_in;
  logic [31:0]   rom_data_out;
  logic          ld_start;
  logic [AW:0]   ld_len;
  logic [7:0]    ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic [AW:0]   ld_words;
  logic          cpu_hold;
`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0]   ld_checksum;
`endif

  inst_rom #(.ADDR_W(AW), .BIG_ENDIAN(BE)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_in    (rom_ce_in),
    .rom_addr_in  (rom_addr_in),
    .rom_data_out (rom_data_out),
    .ld_start     (ld_start),
    .ld_len       (ld_len),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_busy      (ld_busy),
    .ld_done      (ld_done),
    .ld_words     (ld_words),
`ifdef INST_ROM_CHECKSUM_EN
    .ld_checksum  (ld_checksum),
`endif
    .cpu_hold     (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  logic [31:0] model_mem [DEPTH];
  bit          written   [DEPTH];
  logic [31:0] load_buf  [DEPTH];
  logic [31:0] model_csum;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Stream position b of a word: first byte is the most significant one in big-endian order.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input int b);
    return BE ? w[8*(3-b) +: 8] : w[8*b +: 8];
  endfunction

  task automatic fetch_check(input string name, input logic ce, input logic [31:0] addr,
                             input logic [31:0] exp);
    @(negedge clk);
    rom_ce_in   = ce;
    rom_addr_in = addr;
    #1;
    check(name, rom_data_out, exp);
  endtask

  // Full load of nwords from load_buf; gap 0 none, 1 idle every other cycle, 2 random idles.
  task automatic run_load(input int len_field, input int nwords, input int gap, input int inject_at);
    int bi;
    bi = 0;
    @(negedge clk);
    ld_start = 1'b1;
    ld_len   = AW'(0) + (AW+1)'(len_field);
    @(negedge clk);
    ld_start = 1'b0;
    check("busy_rise", 32'(ld_busy), 32'd1);
    check("ready_rise", 32'(ld_ready), 32'd1);
    check("hold_rise", 32'(cpu_hold), 32'd1);
    model_csum = '0;
    for (int w = 0; w < nwords; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
          ld_valid = 1'b0;
          ld_data  = 8'($urandom);
          @(negedge clk);
          check("hold_gap", 32'(cpu_hold), 32'd1);
        end
        ld_valid = 1'b1;
        ld_data  = byte_of(load_buf[w], b);
        if (bi == inject_at) begin
          ld_start = 1'b1;
          ld_len   = (AW+1)'(1);
        end
        check("ready_in_load", 32'(ld_ready), 32'd1);
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        bi++;
        if (!(w == nwords - 1 && b == 3)) check("hold_in_load", 32'(cpu_hold), 32'd1);
      end
      model_mem[w] = load_buf[w];
      written[w]   = 1'b1;
      model_csum   = model_csum + load_buf[w];
    end
    check("done_end", 32'(ld_done), 32'd1);
    check("busy_end", 32'(ld_busy), 32'd0);
    check("hold_end", 32'(cpu_hold), 32'd0);
    check("ready_end", 32'(ld_ready), 32'd0);
    check("words_end", 32'(ld_words), 32'(nwords));
`ifdef INST_ROM_CHECKSUM_EN
    check("checksum_end", ld_checksum, model_csum);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    fetch_vec_t fv[8];
    logic [31:0] old0;
    int n;
    int idx;
    logic ce;
    logic [31:0] addr;

    rst = 1'b0; rom_ce_in = 1'b0; rom_addr_in = '0;
    ld_start = 1'b0; ld_len = '0; ld_data = '0; ld_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      written[i] = 1'b0;
      model_mem[i] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ld_ready), 32'd0);
    check("rst_busy", 32'(ld_busy), 32'd0);
    check("rst_done", 32'(ld_done), 32'd0);
    check("rst_words", 32'(ld_words), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
`ifdef INST_ROM_CHECKSUM_EN
    check("rst_checksum", ld_checksum, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Reference program from the boot sequence
    load_buf[0] = 32'h3402_0001;
    load_buf[1] = 32'h3C03_1234;
    run_load(2, 2, 0, -1);
`ifdef INST_ROM_CHECKSUM_EN
    check("checksum_ref", ld_checksum, 32'h7005_1235);
`endif

    fv[0] = '{"ce0_addr0",   1'b0, 32'h0000_0000, 32'h0000_0000};
    fv[1] = '{"ce1_addr4",   1'b1, 32'h0000_0004, 32'h3C03_1234};
    fv[2] = '{"ce1_addr5",   1'b1, 32'h0000_0005, 32'h3C03_1234};
    fv[3] = '{"ce1_alias",   1'b1, 32'h0000_0004 + 32'(4 * DEPTH), 32'h3C03_1234};
    fv[4] = '{"ce1_addr0",   1'b1, 32'h0000_0000, 32'h3402_0001};
    fv[5] = '{"ce1_addr3",   1'b1, 32'h0000_0003, 32'h3402_0001};
    fv[6] = '{"ce1_hialias", 1'b1, 32'hFFFF_F007, 32'h3C03_1234};
    fv[7] = '{"ce0_addr4",   1'b0, 32'h0000_0004, 32'h0000_0000};
    for (int i = 0; i < 8; i++) fetch_check(fv[i].name, fv[i].ce, fv[i].addr, fv[i].exp);

    // Same program with ld_valid idle every other cycle
    run_load(2, 2, 1, -1);
    fetch_check("gap_w0", 1'b1, 32'h0, 32'h3402_0001);
    fetch_check("gap_w1", 1'b1, 32'h4, 32'h3C03_1234);

    // ld_start pulsed mid-load must not restart or shorten it
    load_buf[0] = $urandom;
    load_buf[1] = $urandom;
    run_load(2, 2, 0, 5);
    fetch_check("inject_w0", 1'b1, 32'h0, model_mem[0]);
    fetch_check("inject_w1", 1'b1, 32'h4, model_mem[1]);

    // Reset after six bytes: word 0 written, partial word 1 discarded
    load_buf[0] = 32'hCAFE_0001;
    load_buf[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    ld_start = 1'b1; ld_len = (AW+1)'(2);
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1;
      ld_data  = byte_of(load_buf[i / 4], i % 4);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    check("midrst_words_before", 32'(ld_words), 32'd1);
    model_mem[0] = load_buf[0];
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(ld_busy), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    check("midrst_ready", 32'(ld_ready), 32'd0);
    check("midrst_words", 32'(ld_words), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    fetch_check("midrst_w0", 1'b1, 32'h0, model_mem[0]);
    fetch_check("midrst_w1_unchanged", 1'b1, 32'h4, model_mem[1]);

    // Bytes offered while idle are not consumed
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = 8'($urandom);
      #1;
      check("idle_ready", 32'(ld_ready), 32'd0);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    fetch_check("idle_no_write", 1'b1, 32'h0, model_mem[0]);

    // Zero-length load goes straight to DONE
    @(negedge clk);
    ld_start = 1'b1; ld_len = '0;
    @(negedge clk);
    ld_start = 1'b0;
    check("len0_done", 32'(ld_done), 32'd1);
    check("len0_words", 32'(ld_words), 32'd0);
    check("len0_busy", 32'(ld_busy), 32'd0);
`ifdef INST_ROM_CHECKSUM_EN
    check("len0_checksum", ld_checksum, 32'd0);
`endif
    fetch_check("len0_no_write", 1'b1, 32'h0, model_mem[0]);

    // Restart from DONE after a zero-length load
    load_buf[0] = $urandom;
    run_load(1, 1, 0, -1);
    fetch_check("restart_w0", 1'b1, 32'h0, model_mem[0]);

    // Fetch of the word being written returns old contents, then new
    old0 = model_mem[0];
    load_buf[0] = ~old0;
    @(negedge clk);
    ld_start = 1'b1; ld_len = (AW+1)'(1);
    @(negedge clk);
    ld_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      ld_valid = 1'b1;
      ld_data  = byte_of(load_buf[0], b);
      @(negedge clk);
    end
    ld_data = byte_of(load_buf[0], 3);
    rom_ce_in = 1'b1; rom_addr_in = 32'h0;
    #1;
    check("rw_same_cycle_old", rom_data_out, old0);
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    check("rw_next_cycle_new", rom_data_out, load_buf[0]);
    check("rw_done", 32'(ld_done), 32'd1);
    model_mem[0] = load_buf[0];

    // Randomized loads with random valid gaps
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) load_buf[i] = $urandom;
      run_load(n, n, 2, -1);
    end

    // Over-long request is clamped to the full depth
    for (int i = 0; i < DEPTH; i++) load_buf[i] = $urandom;
    run_load(DEPTH + 1, DEPTH, 0, -1);
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'hA5;
    #1;
    check("overflow_ready_after", 32'(ld_ready), 32'd0);
    @(negedge clk);
    ld_valid = 1'b0;
    check("overflow_words_hold", 32'(ld_words), 32'(DEPTH));

    // Random fetches against the model, with aliasing and byte offsets
    for (int i = 0; i < 60; i++) begin
      idx  = $urandom_range(0, DEPTH - 1);
      ce   = 1'($urandom_range(0, 3) != 0);
      addr = ($urandom & ~32'(4 * DEPTH - 1)) | 32'(idx * 4) | 32'($urandom_range(0, 3));
      if (written[idx]) fetch_check("rand_fetch", ce, addr, ce ? model_mem[idx] : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_rom.md
# inst_rom

Instruction-memory responder for the CPU fetch port: serves `rom_ce_out`/`rom_addr_out` requests with same-cycle read data on `rom_data_in`. It also contains a byte-stream loader that fills the memory before or between program runs, holding the CPU in reset while loading. It sits at top level beside `cpu`, between the CPU fetch port and the host/boot byte source.

## Interface
Parameters:
- `ADDR_W`, 10: word-address bits; depth = 2^ADDR_W words.
- `BIG_ENDIAN`, 1: 1 = first byte of each word goes to [31:24] (MIPS order); 0 = first byte goes to [7:0].

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rom_ce_in`  in  1  fetch enable from CPU.
- `rom_addr_in`  in  32  fetch byte address.
- `rom_data_out`  out  32  instruction word.
- `ld_start`  in  1  one-cycle pulse: begin a load at word 0.
- `ld_len`  in  ADDR_W+1  number of words to load; sampled on accepted `ld_start`.
- `ld_data`  in  8  load byte.
- `ld_valid`  in  1  `ld_data` valid.
- `ld_ready`  out  1  loader accepts a byte this cycle.
- `ld_busy`  out  1  load in progress.
- `ld_done`  out  1  sticky: last load completed.
- `ld_words`  out  ADDR_W+1  words written in current/last load.
- `cpu_hold`  out  1  drive CPU reset; equals `ld_busy`.
- `ld_checksum`  out  32  present only with `INST_ROM_CHECKSUM_EN`.

## Operation
- Read path, combinational: `rom_data_out` = `rom_ce_in` ? mem[`rom_addr_in`[ADDR_W+1:2]] : 0.
  - Bits [1:0] are ignored, with no alignment fault.
  - Bits above ADDR_W+1 are ignored, so addresses alias (wrap) modulo the depth.
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD on `ld_start` with effective length > 0. Clears word pointer, byte count, `ld_words`, `ld_done` (and checksum).
  - IDLE/DONE with `ld_start` and `ld_len` = 0 → DONE. `ld_words` = 0; `ld_done` = 1 the next cycle.
  - Effective length = min(`ld_len`, 2^ADDR_W).
  - LOAD: `ld_ready` = 1. A byte is accepted when `ld_valid` & `ld_ready`.
    - The byte counter runs 0..3; the 4th accepted byte completes the word.
    - The completed word is written to mem[ptr] at that edge; ptr and `ld_words` increment.
    - When `ld_words` reaches the effective length → DONE.
  - DONE: `ld_ready` = 0, `ld_done` = 1. `ld_start` restarts exactly as from IDLE.
- `ld_start` while in LOAD is ignored; the load continues.
- `ld_valid` outside LOAD is ignored, and no byte is consumed.
- Partial word at reset: discarded; memory is unchanged.
- Memory contents are not reset; only control state is.
- Read and write to the same word in the same cycle: the read returns the old contents. The new word is visible the cycle after the write edge.

## Timing
- Reset values: `ld_ready` 0, `ld_busy` 0, `ld_done` 0, `ld_words` 0, `cpu_hold` 0, `ld_checksum` 0, state IDLE.
- `rom_data_out` has no reset value (combinational from memory/`rom_ce_in`).
- Read latency is 0 cycles: data is valid in the same cycle as the address, and `if_id` captures it at the next edge.
- `ld_busy`/`cpu_hold`/`ld_ready` rise the cycle after `ld_start`.
- They fall the cycle after the final byte's accepting edge; `ld_done` rises in that same cycle.
- Throughput: 1 byte per cycle; N words take ≥ 4N cycles after start.
- Reset asserted mid-LOAD forces IDLE immediately (asynchronously) and drops `cpu_hold`.

## Configuration
- `INST_ROM_CHECKSUM_EN` defined:
  - `ld_checksum` port exists.
  - It holds the sum mod 2^32 of all words written in the current/last load.
  - It is cleared on accepted `ld_start` and updated at each word-write edge.
- Undefined: the port and the adder are absent; all other behaviour is identical.

## Structure
- Shared package/defines:
  - loader state encoding (IDLE/LOAD/DONE);
  - `RegBus`/`InstAddrBus` widths, reused from the CPU defines;
  - default ADDR_W.
- One sub-module: `inst_rom_ld_fsm`. It holds the handshake, byte assembly, pointer, counters and checksum, and emits write-enable/address/data to the memory array kept in `inst_rom`.

## Test plan
- Reset, then `ld_start` with `ld_len`=2, BIG_ENDIAN=1, bytes 34 02 00 01 3C 03 12 34 →
  - mem[0]=0x34020001, mem[1]=0x3C031234;
  - `ld_done` 1, `ld_words` 2;
  - checksum 0x70051235 (with macro).
- Fetch with `rom_ce_in`=0 at addr 0 → data 0. With `rom_ce_in`=1 at 0x4, 0x5, and 0x4+4·2^ADDR_W → 0x3C031234 every time.
- `ld_valid` toggling every other cycle during LOAD → the same words are written, only on valid&ready edges; `cpu_hold` stays high throughout.
- `ld_start` mid-LOAD → ignored. `rst` low after 6 bytes → IDLE, mem[1] unchanged, `ld_words` 0.
- `ld_len`=0 → DONE next cycle, no writes. `ld_len`=2^ADDR_W+1 → stops after 2^ADDR_W words.
- Same-cycle fetch of the word being written → old value, new value one cycle later.
